nanosoc_rr_output_arbiter: RTL

//  Round-robin output-stage arbiter for the nanosoc bus matrix; one instance per slave port.

---
 rtl/nanosoc_bm_pkg.sv | 33 +++
 rtl/nanosoc_burst_tracker.sv | 76 +++++++
 rtl/nanosoc_rr_output_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/nanosoc_bm_pkg.sv
// Shared bus-matrix definitions: AHB transfer/burst codes and burst length helper.
package nanosoc_bm_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  // Number of SEQ beats that follow the NONSEQ of a fixed-length burst;
  // zero for SINGLE and undefined-length INCR, which are never protected.
  function automatic logic [3:0] burst_beats(input hburst_t hburst);
    case (hburst)
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
      default:                      burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/nanosoc_burst_tracker.sv
// Tracks the remaining beats of a fixed-length burst on an output port and
// raises next_hold while that burst must not be split. Repeated NONSEQs inside
// a protected burst are treated as early termination and eventually release it.
module nanosoc_burst_tracker
  import nanosoc_bm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic       sel,
  input  logic [1:0] trans,
  input  logic [2:0] burst,
  output logic       next_hold
);

  logic [3:0] cnt;
  logic       hold;
  logic [1:0] early_term_cnt;
  logic [3:0] next_cnt;
  logic [1:0] next_early_term_cnt;

  // Next burst state from the transfer currently on the output port.
  always_comb begin
    next_cnt            = cnt;
    next_hold           = hold;
    next_early_term_cnt = early_term_cnt;
    if (!sel) begin
      next_cnt  = 4'd0;
      next_hold = 1'b0;
    end else begin
      case (htrans_t'(trans))
        HTRANS_IDLE: begin
          next_cnt  = 4'd0;
          next_hold = 1'b0;
        end
        HTRANS_NONSEQ: begin
          if (early_term_cnt == 2'd2) begin
            next_cnt  = 4'd0;
            next_hold = 1'b0;
          end else begin
            next_cnt  = burst_beats(hburst_t'(burst));
            next_hold = (next_cnt != 4'd0);
            if (hold) begin
              next_early_term_cnt = early_term_cnt + 2'd1;
            end
          end
        end
        HTRANS_SEQ: begin
          next_cnt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            next_hold = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
    if (!next_hold) begin
      next_early_term_cnt = 2'd0;
    end
  end

  // Burst state advances only on completed transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= 4'd0;
      hold           <= 1'b0;
      early_term_cnt <= 2'd0;
    end else if (ready) begin
      cnt            <= next_cnt;
      hold           <= next_hold;
      early_term_cnt <= next_early_term_cnt;
    end
  end

endmodule

// File: rtl/nanosoc_rr_output_arbiter.sv
// Round-robin output-stage arbiter: one per slave port. Keeps fixed bursts and
// locked sequences intact and limits how long an INCR stream holds the port.
module nanosoc_rr_output_arbiter
  import nanosoc_bm_pkg::*;
#(
  parameter int NPORTS     = 4,
  parameter int PW         = 2,
  parameter int INCR_LIMIT = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [NPORTS-1:0] req_port,
  input  logic              HREADYM,
  input  logic              HSELM,
  input  logic [1:0]        HTRANSM,
  input  logic [2:0]        HBURSTM,
  input  logic              HMASTLOCKM,
  output logic [PW-1:0]     addr_in_port,
  output logic [NPORTS-1:0] grant_onehot,
  output logic              no_port
);

  localparam logic [7:0] LIMIT = 8'(INCR_LIMIT);

  logic                next_hold;
  logic [PW-1:0]       ptr;
  logic [7:0]          incr_cnt;
  logic                limit_hit;
  logic                owner_active;
  logic [NPORTS-1:0]   masked_req;
  logic [2*NPORTS-1:0] dbl_req;
  logic [PW:0]         idx;
  logic                found;
  logic [PW-1:0]       winner;
  logic [PW-1:0]       next_addr;
  logic                next_no_port;
  logic [NPORTS-1:0]   next_onehot;
  logic [PW-1:0]       next_ptr;
  logic                take_winner;
  logic                owner_change;

  nanosoc_burst_tracker u_tracker (
    .clk       (HCLK),
    .reset     (HRESET),
    .ready     (HREADYM),
    .sel       (HSELM),
    .trans     (HTRANSM),
    .burst     (HBURSTM),
    .next_hold (next_hold)
  );

  // Fairness limit and the request set offered to the round-robin search.
  always_comb begin
    owner_active = HSELM && (HTRANSM != HTRANS_IDLE);
    limit_hit    = (incr_cnt == LIMIT) && (|(req_port & ~grant_onehot));
    masked_req   = limit_hit ? (req_port & ~grant_onehot) : req_port;
  end

  // First requester at or after ptr, wrapping through a doubled request vector.
  always_comb begin
    dbl_req = {masked_req, masked_req};
    idx     = '0;
    found   = 1'b0;
    winner  = '0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (!found && dbl_req[idx]) begin
        found  = 1'b1;
        winner = (idx >= (PW+1)'(NPORTS)) ? PW'(idx - (PW+1)'(NPORTS)) : PW'(idx);
      end
    end
  end

  // Grant decision in priority order: lock/burst, active owner, search, idle.
  always_comb begin
    next_addr    = addr_in_port;
    next_no_port = no_port;
    take_winner  = 1'b0;
    if (HMASTLOCKM || next_hold) begin
      next_addr    = addr_in_port;
    end else if (owner_active && !limit_hit) begin
      next_addr    = addr_in_port;
    end else if (found) begin
      next_addr    = winner;
      next_no_port = 1'b0;
      take_winner  = 1'b1;
    end else if (HSELM) begin
      next_no_port = 1'b0;
    end else begin
      next_no_port = 1'b1;
    end
    next_onehot  = next_no_port ? '0 : (NPORTS'(1) << next_addr);
    next_ptr     = (winner == PW'(NPORTS - 1)) ? '0 : winner + 1'b1;
    owner_change = !next_no_port && (no_port || (next_addr != addr_in_port));
  end

  // Registered grant, round-robin pointer and INCR beat counter.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      grant_onehot <= '0;
      ptr          <= '0;
      incr_cnt     <= 8'd0;
    end else if (HREADYM) begin
      addr_in_port <= next_addr;
      no_port      <= next_no_port;
      grant_onehot <= next_onehot;
      if (take_winner) begin
        ptr <= next_ptr;
      end
      if (owner_change || (HTRANSM == HTRANS_IDLE)) begin
        incr_cnt <= 8'd0;
      end else if (HSELM && !next_hold && incr_cnt != LIMIT &&
                   (HTRANSM == HTRANS_NONSEQ || HTRANSM == HTRANS_SEQ)) begin
        incr_cnt <= incr_cnt + 8'd1;
      end
    end
  end

endmodule
